// File: rtl/decrypt_msg_checker_if.sv
// Read-side bus between the decrypted-message checker, its controller and the message RAM.
interface decrypt_msg_checker_if;
  logic       start;
  logic [7:0] msg_data;
  logic [7:0] msg_addr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] bad_addr;

  modport slave (
    input  start, msg_data,
    output msg_addr, busy, done, pass, bad_addr
  );

  modport master (
    output start, msg_data,
    input  msg_addr, busy, done, pass, bad_addr
  );
endinterface

// File: rtl/decrypt_msg_checker.sv
// Scans the decrypted-message RAM and accepts the message only if every byte is 'a'..'z' or space.
module decrypt_msg_checker #(
  parameter int unsigned MSG_LEN = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  decrypt_msg_checker_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSetAddr,
    StWaitRd,
    StCheck,
    StFinish
  } state_e;

  // Nine bits so that MSG_LEN = 256 ends on the compare instead of wrapping.
  localparam logic [8:0] LastIdx = 9'(MSG_LEN - 1);

  state_e     state_q;
  logic [8:0] idx_q;
  logic [7:0] addr_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] bad_q;
  logic       byte_ok;

  assign byte_ok = (bus.msg_data == 8'h20) ||
                   ((bus.msg_data >= 8'h61) && (bus.msg_data <= 8'h7A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      bad_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            idx_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSetAddr;
          end
        end
        StSetAddr: begin
          addr_q  <= idx_q[7:0];
          state_q <= StWaitRd;
        end
        StWaitRd: begin
          state_q <= StCheck;
        end
        StCheck: begin
          if (!byte_ok) begin
            bad_q   <= idx_q[7:0];
            pass_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else if (idx_q == LastIdx) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            idx_q   <= idx_q + 9'd1;
            state_q <= StSetAddr;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.msg_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.bad_addr = bad_q;

endmodule
